// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin front end that shares one single-port data RAM
// between two masters. Each access is sequenced by a small FSM; writes with
// a partial byte-enable become a read-modify-write over two RAM cycles.
module ram_arbiter #(
  parameter int DEPTH = 256,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  // requester 0 (CPU load/store unit)
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [31:0]     m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_done,
  output logic            m0_err,
  output logic [DW-1:0]   m0_rdata,
  // requester 1 (DMA / debug)
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [31:0]     m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_done,
  output logic            m1_err,
  output logic [DW-1:0]   m1_rdata,
  // RAM pins (combinational read, write on posedge clk)
  output logic            ram_we,
  output logic [31:0]     ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
);

  localparam int          BW      = DW / 8;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [BW-1:0] be;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_t        state;
  cmd_t          cmd;          // command latched at grant
  cmd_t          m0_cmd;
  cmd_t          m1_cmd;
  cmd_t          grant_cmd;
  logic          owner;        // 0 = m0, 1 = m1
  logic          last_served;
  logic [DW-1:0] merged;       // read-modify-write result, written in RMW_WR

  logic          grant_any;
  logic          grant_sel;
  logic          in_range;
  logic          full_wr;
  logic          partial_wr;
  logic          enter_resp;
  logic          rd_load;
  logic [DW-1:0] be_mask;
  logic [DW-1:0] rd_val;

  assign m0_cmd = '{we: m0_we, be: m0_be, addr: m0_addr, wdata: m0_wdata};
  assign m1_cmd = '{we: m1_we, be: m1_be, addr: m1_addr, wdata: m1_wdata};

  // Round-robin choice: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_any = m0_req | m1_req;
    grant_sel = (m0_req && m1_req) ? ~last_served : m1_req;
    grant_cmd = grant_sel ? m1_cmd : m0_cmd;
  end

  // Grants are only offered while idle.
  assign m0_gnt = (state == IDLE) && grant_any && !grant_sel;
  assign m1_gnt = (state == IDLE) && grant_any &&  grant_sel;

  // Classify the latched command and build the byte mask for merging.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    be_mask = '0;
    for (int i = 0; i < BW; i++) begin
      be_mask[8*i +: 8] = {8{cmd.be[i]}};
    end
    in_range   = cmd.addr < DEPTH_W;
    full_wr    = in_range && cmd.we && (&cmd.be);
    partial_wr = in_range && cmd.we && (|cmd.be) && !(&cmd.be);
    enter_resp = ((state == ACCESS) && !partial_wr) || (state == RMW_WR);
    rd_load    = (state == ACCESS) && (!in_range || !cmd.we);
    rd_val     = in_range ? ram_rdata : '0;
  end

  // RAM pin drive, decoded from the current state and the latched command.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      ACCESS: begin
        ram_addr = cmd.addr;
        if (full_wr) begin
          ram_we    = 1'b1;
          ram_wdata = cmd.wdata;
        end
      end
      RMW_WR: begin
        ram_we    = 1'b1;
        ram_addr  = cmd.addr;
        ram_wdata = merged;
      end
      RESP:    ram_addr = cmd.addr;
      default: ;
    endcase
  end

  // Access sequencer plus registered per-port response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      owner       <= 1'b0;
      cmd         <= '0;
      merged      <= '0;
      m0_done     <= 1'b0;
      m0_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_done     <= 1'b0;
      m1_err      <= 1'b0;
      m1_rdata    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge value regardless of statement order.
      m0_done <= enter_resp && !owner;
      m1_done <= enter_resp &&  owner;
      m0_err  <= enter_resp && !owner && !in_range;
      m1_err  <= enter_resp &&  owner && !in_range;
      if (rd_load && !owner) m0_rdata <= rd_val;
      if (rd_load &&  owner) m1_rdata <= rd_val;

      case (state)
        IDLE: begin
          if (grant_any) begin
            cmd         <= grant_cmd;
            owner       <= grant_sel;
            last_served <= grant_sel;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (partial_wr) begin
            merged <= (ram_rdata & ~be_mask) | (cmd.wdata & be_mask);
            state  <= RMW_WR;
          end else begin
            state <= RESP;
          end
        end
        RMW_WR:  state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
